fetch_stage: RTL
================

# fetch_stage

Instruction fetch stage of the pipelined RV32 core. It holds the architectural fetch PC, issues in-order read requests to instruction memory, tracks outstanding requests, and buffers returned words in a small queue. It presents one `fetched_instruction_t` per cycle to decode. It obeys the `stage_signal_t` advance/flush and `fetch_set_pc_call_t` redirect produced by the pipeline control unit, and discards stale responses after a redirect.

## Interface

Parameters:
- `RESET_PC`, 32'h0000_0000: first fetch address after reset.
- `DEPTH`, 2: maximum of in-flight requests plus queued instructions; also the queue size; must be ≥2.

Ports:
- `clk`  in  1  core clock; all state on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `fetch_signal_in`  in  `stage_signal_t`  `advance`: decode consumes the head this cycle; `flush`: discard queue.
- `fetch_set_pc_call_in`  in  `fetch_set_pc_call_t`  `valid` + `pc`: redirect.
- `inst_mem_req`  out  `memory_io_req`  uses `valid`, `addr`, `do_read`=4'b1111, `do_write`=0, `user_tag[0]`=epoch.
- `inst_mem_req_ready`  in  1  memory accepts `inst_mem_req` when `valid && ready`.
- `inst_mem_rsp`  in  `memory_io_rsp`  uses `valid`, `data`, `user_tag[0]`; responses return in request order, at most one per cycle.
- `fetched_instruction_out`  out  `fetched_instruction_t`  `valid`, `pc`, `instruction`; this is the queue head.

## Operation

State:
- `pc_q` (32b): next address to request.
- `epoch_q` (1b).
- `outstanding_q` ($clog2(DEPTH+1) bits).
- Queue of `{pc, instruction}` entries with `count`.
- Side FIFO of request PCs, `DEPTH` deep, paired with responses.

Per cycle:
- pop = `fetched_instruction_out.valid && fetch_signal_in.advance && !fetch_signal_in.flush`.
- Issue condition: `!redirect && (outstanding_q + count − pop) < DEPTH`. `inst_mem_req.valid` equals the issue condition. The request is accepted when `inst_mem_req_ready` is high: `pc_q += 4`, `outstanding_q++`, and the PC is pushed to the side FIFO.
- Response: `outstanding_q--` and the side FIFO pops. If `user_tag[0] == epoch_q`, `{side_pc, data}` is pushed to the queue. Otherwise the response is dropped.
- Simultaneous accept and response: `outstanding_q` is unchanged.

Redirect and flush:
- Redirect (`fetch_set_pc_call_in.valid`): `pc_q <= pc`, `epoch_q` toggles, queue clears, and no request is issued that cycle. Outstanding responses still drain via the counter and side FIFO, then drop on epoch mismatch.
- `flush` without redirect: queue clears and epoch toggles; `pc_q` is unchanged. Control always pairs the two; an assertion flags a lone flush.
- Redirect and pop in the same cycle: redirect wins and the queue is empty next cycle.
- A response arriving in a redirect cycle always carries the old epoch and is dropped.

Boundaries:
- Queue never overflows, by credit.
- `pc_q` wraps 32'hFFFF_FFFC → 0.
- Assertions: redirect `pc[1:0]==0`; response with `outstanding_q==0` is illegal.

## Timing

Reset values:
- `pc_q`=`RESET_PC`, `epoch_q`=0, `outstanding_q`=0, queue empty.
- `inst_mem_req.valid`=0 while reset is asserted. `fetched_instruction_out.valid`=0, pc=0, instruction=0.

Latency and throughput:
- First request is in the first cycle after reset release.
- Request accepted in cycle N, response in N+k: the instruction is valid on the output in N+k+1 (registered queue).
- Throughput is one instruction per cycle with `DEPTH`=2 and 1-cycle memory. The pop term makes issue combinationally dependent on `advance`.
- Redirect in cycle R: new-PC request in R+1; with 1-cycle memory, output valid in R+3.
- Reset asserted mid-operation clears everything asynchronously. Responses to pre-reset requests are the memory's responsibility (memory is reset too).

## Structure

- `riscv32_common` package: `fetched_instruction_t`, `stage_signal_t`, `fetch_set_pc_call_t`, `memory_io_req`, `memory_io_rsp` (existing).
- Add to the package:
  - `fetch_entry_t` {pc, instruction}.
  - Constant `INST_BYTES`=4.
- One sub-module: `fetch_queue`, a parameterised synchronous FIFO with single-cycle `clear`, push, pop, `count`, and head output. Instantiated twice: instruction queue and side PC FIFO (data-only width).

## Test plan

- Reset with `RESET_PC`=32'h100, memory ready, 1-cycle latency, advance=1 → requests 0x100, 0x104, 0x108 in consecutive cycles; outputs {0x100,…} valid from the third cycle, one per cycle.
- advance=0 for 5 cycles → at most 2 requests in flight+queued, `inst_mem_req.valid` drops, head holds 0x100; advance=1 resumes 0x104 with no gap or duplicate.
- Redirect to 0x200 with 2 responses outstanding (3-cycle memory) → both old responses dropped; first output pc=0x200, next 0x204.
- `inst_mem_req_ready`=0 for 4 cycles → `pc_q` holds, request held stable with valid=1, no output.
- Redirect in the same cycle as pop and a response arrival → response dropped, queue empty next cycle, next request addr = redirect pc.
- Redirect to 0xFFFF_FFFC → outputs 0xFFFF_FFFC then 0x0000_0000.

Source files
------------

// File: rtl/riscv32_common_pkg.sv
// Shared RV32 pipeline types: stage control, redirect, memory port and fetch-queue entry.
package riscv32_common;

    localparam int          USER_TAG_W = 1;
    localparam logic [31:0] INST_BYTES = 32'd4;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] instruction;
    } fetched_instruction_t;

    typedef struct packed {
        logic advance;
        logic flush;
    } stage_signal_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
    } fetch_set_pc_call_t;

    typedef struct packed {
        logic                  valid;
        logic [31:0]           addr;
        logic [31:0]           data;
        logic [3:0]            do_read;
        logic [3:0]            do_write;
        logic [USER_TAG_W-1:0] user_tag;
    } memory_io_req;

    typedef struct packed {
        logic                  valid;
        logic [31:0]           data;
        logic [USER_TAG_W-1:0] user_tag;
    } memory_io_rsp;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instruction;
    } fetch_entry_t;

    function automatic logic [31:0] next_fetch_pc(input logic [31:0] pc);
        return pc + INST_BYTES;
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// Small synchronous FIFO with single-cycle clear; head always shows the oldest entry.
module fetch_queue #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2,
    localparam int CNT_W = $clog2(DEPTH + 1),
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] push_data,
    output logic [WIDTH-1:0] head,
    output logic [CNT_W-1:0] count
);
    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0] rd_ptr_r;
    logic [PTR_W-1:0] wr_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic             push_ok_s;
    logic             pop_ok_s;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1'b1);
    endfunction

    // Pop only real entries; push only into free space or a slot freed this cycle.
    always_comb begin
        pop_ok_s  = pop && (count_r != '0);
        push_ok_s = push && ((count_r != CNT_W'(DEPTH)) || pop_ok_s);
    end

    // Pointer, count and storage update; clear takes priority over push and pop.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr_r <= '0;
            wr_ptr_r <= '0;
            count_r  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
        end else if (clear) begin
            rd_ptr_r <= '0;
            wr_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (push_ok_s) begin
                mem_r[wr_ptr_r] <= push_data;
                wr_ptr_r        <= ptr_inc(wr_ptr_r);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= ptr_inc(rd_ptr_r);
            end
            count_r <= count_r + CNT_W'(push_ok_s) - CNT_W'(pop_ok_s);
        end
    end

    assign head  = mem_r[rd_ptr_r];
    assign count = count_r;

endmodule

// File: rtl/fetch_stage_checker.sv
// Protocol checks on fetch-stage control inputs and in-flight request bookkeeping.
module fetch_stage_checker #(
    parameter int CNT_W = 2
) (
    input logic             clk,
    input logic             reset,
    input logic             redirect,
    input logic [1:0]       redirect_pc_low,
    input logic             flush,
    input logic             rsp_valid,
    input logic [CNT_W-1:0] outstanding,
    input logic [CNT_W-1:0] side_count
);
    a_redirect_aligned: assert property (@(posedge clk) disable iff (!reset)
        redirect |-> (redirect_pc_low == 2'b00));

    a_no_lone_flush: assert property (@(posedge clk) disable iff (!reset)
        flush |-> redirect);

    a_rsp_expected: assert property (@(posedge clk) disable iff (!reset)
        rsp_valid |-> (outstanding != '0));

    a_side_fifo_tracks: assert property (@(posedge clk) disable iff (!reset)
        side_count == outstanding);

endmodule

// File: rtl/fetch_stage.sv
// RV32 instruction fetch: holds the fetch PC, issues in-order reads under a credit limit,
// and queues returned words for decode; an epoch bit discards responses from before a redirect.
module fetch_stage
    import riscv32_common::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  stage_signal_t        fetch_signal_in,
    input  fetch_set_pc_call_t   fetch_set_pc_call_in,
    output memory_io_req         inst_mem_req,
    input  logic                 inst_mem_req_ready,
    input  memory_io_rsp         inst_mem_rsp,
    output fetched_instruction_t fetched_instruction_out
);
    localparam int CNT_W  = $clog2(DEPTH + 1);
    localparam int LOAD_W = CNT_W + 1;

    logic [31:0]      pc_r;
    logic             epoch_r;
    logic [CNT_W-1:0] outstanding_r;

    logic              redirect_s;
    logic              flush_s;
    logic              clear_s;
    logic              head_valid_s;
    logic              pop_s;
    logic [LOAD_W-1:0] load_s;
    logic              issue_s;
    logic              accept_s;
    logic              rsp_valid_s;
    logic              rsp_keep_s;
    logic [CNT_W-1:0]  q_count_s;
    logic [CNT_W-1:0]  side_count_s;
    logic [31:0]       side_pc_s;
    fetch_entry_t      q_head_s;
    fetch_entry_t      q_push_s;

    // Credit check and handshake decode; pop frees a slot in the same cycle.
    always_comb begin
        redirect_s   = fetch_set_pc_call_in.valid;
        flush_s      = fetch_signal_in.flush;
        clear_s      = redirect_s || flush_s;
        head_valid_s = (q_count_s != '0);
        pop_s        = head_valid_s && fetch_signal_in.advance && !flush_s;
        load_s       = LOAD_W'(outstanding_r) + LOAD_W'(q_count_s) - LOAD_W'(pop_s);
        issue_s      = reset && !redirect_s && (load_s < LOAD_W'(DEPTH));
        accept_s     = issue_s && inst_mem_req_ready;
        rsp_valid_s  = inst_mem_rsp.valid;
        rsp_keep_s   = rsp_valid_s && (inst_mem_rsp.user_tag[0] == epoch_r) && !clear_s;
        q_push_s.pc          = side_pc_s;
        q_push_s.instruction = inst_mem_rsp.data;
    end

    // Memory request and decode-facing head presentation.
    always_comb begin
        inst_mem_req             = '0;
        inst_mem_req.valid       = issue_s;
        inst_mem_req.addr        = pc_r;
        inst_mem_req.do_read     = 4'b1111;
        inst_mem_req.do_write    = 4'b0000;
        inst_mem_req.user_tag[0] = epoch_r;
        fetched_instruction_out  = '0;
        if (head_valid_s) begin
            fetched_instruction_out.valid       = 1'b1;
            fetched_instruction_out.pc          = q_head_s.pc;
            fetched_instruction_out.instruction = q_head_s.instruction;
        end else begin
            fetched_instruction_out = '0;
        end
    end

    // Fetch PC, epoch and in-flight counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_r          <= RESET_PC;
            epoch_r       <= 1'b0;
            outstanding_r <= '0;
        end else begin
            if (redirect_s) begin
                pc_r <= fetch_set_pc_call_in.pc;
            end else if (accept_s) begin
                pc_r <= next_fetch_pc(pc_r);
            end else begin
                pc_r <= pc_r;
            end
            epoch_r <= epoch_r ^ clear_s;
            case ({accept_s, rsp_valid_s})
                2'b10:   outstanding_r <= outstanding_r + CNT_W'(1'b1);
                2'b01:   outstanding_r <= outstanding_r - CNT_W'(1'b1);
                default: outstanding_r <= outstanding_r;
            endcase
        end
    end

    fetch_queue #(
        .WIDTH($bits(fetch_entry_t)),
        .DEPTH(DEPTH)
    ) u_inst_queue (
        .clk       (clk),
        .reset     (reset),
        .clear     (clear_s),
        .push      (rsp_keep_s),
        .pop       (pop_s),
        .push_data (q_push_s),
        .head      (q_head_s),
        .count     (q_count_s)
    );

    // Request PCs ride alongside the memory so each response is paired with its address.
    fetch_queue #(
        .WIDTH(32),
        .DEPTH(DEPTH)
    ) u_side_pc_fifo (
        .clk       (clk),
        .reset     (reset),
        .clear     (1'b0),
        .push      (accept_s),
        .pop       (rsp_valid_s),
        .push_data (pc_r),
        .head      (side_pc_s),
        .count     (side_count_s)
    );

    fetch_stage_checker #(
        .CNT_W(CNT_W)
    ) u_checker (
        .clk             (clk),
        .reset           (reset),
        .redirect        (redirect_s),
        .redirect_pc_low (fetch_set_pc_call_in.pc[1:0]),
        .flush           (flush_s),
        .rsp_valid       (rsp_valid_s),
        .outstanding     (outstanding_r),
        .side_count      (side_count_s)
    );

endmodule
